// File: rtl/hilo_md_unit.sv
// HI/LO writer: executes mult/multu/div/divu/mthi/mtlo from EX and drives the
// HI/LO write bus, stalling the front end while a multiply or divide is pending.
module hilo_md_unit #(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        stall_req,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy
);

    // state   | meaning
    // IDLE    | accepting ops; mthi/mtlo complete here
    // DIV_RUN | one restoring-division iteration per cycle
    // DONE    | result on hi_o/lo_o with both enables set for one cycle
    typedef enum logic [1:0] {IDLE, DIV_RUN, DONE} state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam int CW = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     rem_q, quot_q, dvsr_q;
    logic            q_neg_q, r_neg_q;

    logic            is_mul, is_div, op_signed, last_iter;
    logic [63:0]     prod_s, prod_u;
    logic [31:0]     abs1, abs2;
    logic [32:0]     shifted, diff;
    logic [31:0]     rem_nx, quot_nx, rem_fix, quot_fix;

    assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
    assign op_signed = (op == OP_DIV);
    assign last_iter = (cnt_q == CW'(DIV_ITER - 1));

    assign prod_s = {{32{src1[31]}}, src1} * {{32{src2[31]}}, src2};
    assign prod_u = {32'd0, src1} * {32'd0, src2};
    assign abs1   = (op_signed && src1[31]) ? -src1 : src1;
    assign abs2   = (op_signed && src2[31]) ? -src2 : src2;

    // Shifted remainder needs 33 bits: rem < divisor can still reach 2^32 after the shift.
    assign shifted  = {rem_q, quot_q[31]};
    assign diff     = shifted - {1'b0, dvsr_q};
    assign rem_nx   = diff[32] ? shifted[31:0] : diff[31:0];
    assign quot_nx  = {quot_q[30:0], ~diff[32]};
    assign quot_fix = q_neg_q ? -quot_nx : quot_nx;
    assign rem_fix  = r_neg_q ? -rem_nx  : rem_nx;

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        stall_req = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (is_mul || is_div)) begin
                        stall_req = 1'b1;
                        state_d   = (is_div && (src2 != 32'd0)) ? DIV_RUN : DONE;
                    end
                end
                DIV_RUN: begin
                    stall_req = 1'b1;
                    if (last_iter) state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_we   <= 1'b0;
            lo_we   <= 1'b0;
            hi_o    <= 32'd0;
            lo_o    <= 32'd0;
            cnt_q   <= '0;
            rem_q   <= 32'd0;
            quot_q  <= 32'd0;
            dvsr_q  <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            hi_we <= 1'b0;
            lo_we <= 1'b0;
            if (!flush) begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            case (op)
                                OP_MTHI: begin
                                    hi_we <= 1'b1;
                                    hi_o  <= src1;
                                end
                                OP_MTLO: begin
                                    lo_we <= 1'b1;
                                    lo_o  <= src1;
                                end
                                OP_MULT, OP_MULTU: begin
                                    hi_we <= 1'b1;
                                    lo_we <= 1'b1;
                                    {hi_o, lo_o} <= (op == OP_MULT) ? prod_s : prod_u;
                                end
                                OP_DIV, OP_DIVU: begin
                                    if (src2 == 32'd0) begin
                                        hi_we <= 1'b1;
                                        lo_we <= 1'b1;
                                        hi_o  <= src1;
                                        lo_o  <= 32'hFFFF_FFFF;
                                    end else begin
                                        cnt_q   <= '0;
                                        rem_q   <= 32'd0;
                                        quot_q  <= abs1;
                                        dvsr_q  <= abs2;
                                        q_neg_q <= op_signed && (src1[31] ^ src2[31]);
                                        r_neg_q <= op_signed && src1[31];
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    DIV_RUN: begin
                        rem_q  <= rem_nx;
                        quot_q <= quot_nx;
                        cnt_q  <= cnt_q + CW'(1);
                        if (last_iter) begin
                            hi_we <= 1'b1;
                            lo_we <= 1'b1;
                            hi_o  <= rem_fix;
                            lo_o  <= quot_fix;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/hilo_md_unit.md
Name: hilo_md_unit

Overview:
- Writer side of the HI/LO register interface.
- Executes MIPS mult/multu/div/divu/mthi/mtlo issued from EX.
- Produces the HI/LO write-enable and data fields that feed the register file's hl write bus and the EX/MEM/WB forwarding buses.
- Raises a stall request while a multi-cycle multiply or divide is in flight.

Parameters:
- DIV_ITER, 32: radix-2 restoring-division iterations; equals the operand width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous cancel; squashes the in-flight op.
- start  in  1  EX holds a valid HI/LO-writing instruction this cycle.
- op  in  3  operation: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; others are no-op.
- src1  in  32  rs operand (dividend / multiplicand / mthi-mtlo value).
- src2  in  32  rt operand (divisor / multiplier).
- stall_req  out  1  hold IF/ID/EX; combinational.
- hi_we  out  1  HI write enable, registered.
- lo_we  out  1  LO write enable, registered.
- hi_o  out  32  HI write data, registered.
- lo_o  out  32  LO write data, registered.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE; hi_we=lo_we=0; hi_o=lo_o=0; counter=0; busy=0.
- States: IDLE, DIV_RUN, DONE.
- IDLE, start=1:
  - mthi: next cycle hi_we=1, hi_o=src1, lo_we=0. No stall. Stay IDLE.
  - mtlo: same, on LO.
  - mult / multu: 64-bit signed / unsigned product of src1 × src2 latched. stall_req=1 this cycle. Next state DONE.
  - div / divu, src2≠0:
    - Latch |src1| and |src2| (raw values for divu).
    - Latch the quotient sign (s1^s2) and remainder sign (s1); both signed-only.
    - stall_req=1, counter=0, next state DIV_RUN.
  - div / divu, src2=0: result HI=src1, LO=32'hFFFFFFFF, no sign fixup. stall_req=1, next state DONE.
  - Invalid op: ignored.
- DIV_RUN:
  - Each cycle: shift the {rem,quot} pair left by 1, trial-subtract the divisor from rem, set the quotient bit if the result is non-negative.
  - counter increments each cycle; after iteration DIV_ITER-1, next state DONE.
  - stall_req=1 throughout.
  - start is ignored.
- DONE:
  - Outputs are the registered result: hi_we=lo_we=1 for exactly one cycle. HI=remainder / product[63:32]; LO=quotient / product[31:0].
  - Signed divide: negate the quotient if its sign=1; negate the remainder if the dividend sign=1.
  - stall_req=0.
  - start is ignored, because the same instruction is still in EX.
  - Next state IDLE.
- Write enables are otherwise 0. hi_o and lo_o hold their last value when not written.
- Latency with start at cycle T:
  - mthi/mtlo: write at T+1.
  - mult/multu: stall at T, write at T+1.
  - div/divu: stall T..T+32, write at T+33.
  - Divide by zero: stall T, write T+1.
- Overflow case: div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (natural wrap).
- flush=1 in any state:
  - Next state IDLE, next-cycle hi_we=lo_we=0, no pending write.
  - flush has priority over start.
  - stall_req is forced to 0 in the flush cycle.
- rst asserted mid-division: immediate return to IDLE, outputs cleared. No write ever emerges.

Test Plan:
- divu src1=7, src2=2 -> stall_req high 33 cycles; at T+33 hi_we=lo_we=1, HI=1, LO=3; stall_req low at T+33.
- div src1=0xFFFFFFF9 (-7), src2=2 -> at T+33 LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mult src1=0xFFFFFFFF, src2=2 -> T+1: HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 on back-to-back cycles:
  - Each write appears one cycle later with only its own enable set.
  - stall_req never asserts.
- div by zero (src1=5, src2=0) -> stall 1 cycle; T+1: HI=5, LO=0xFFFFFFFF.
- flush at T+10 of divu, and separately rst low at T+10 -> no hi_we/lo_we pulse at T+33, busy=0 from T+11. A new mult at T+12 completes normally.
